// File: rtl/io_input_port.sv
// io_input_port: synchronizes and debounces board switches and push-buttons and
// exposes them as a memory-mapped STATUS register plus a read-to-clear EVENT register.
module io_input_port #(
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned STABLE_SAMPLES = 4,
  parameter logic [15:0] STATUS_ADDR    = 16'h3FFE,
  parameter logic [15:0] EVENT_ADDR     = 16'h3FFD
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [15:0] dataAddress,
  input  logic        dataRdEn,
  input  logic [9:0]  SW,
  input  logic [2:0]  BUTTON,
  output logic [31:0] readDataOut,
  output logic        readValid
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned NIN   = 13;
  localparam int unsigned HIST  = STABLE_SAMPLES - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  // Buttons sit in the top three bits in raw (active-low) polarity, so idle is all ones.
  localparam logic [NIN-1:0] RESET_LEVEL = {3'b111, 10'b0};

  logic [NIN-1:0]            sync1_q, sync2_q;
  logic [HIST-1:0][NIN-1:0]  hist_q, hist_d;
  logic [NIN-1:0]            level_q, level_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      tick_q, tick_d;
  logic [5:0]                event_q, event_d;
  logic [31:0]               readData_d;
  logic                      readValid_d;

  logic [NIN-1:0] allOnes, allZeros;
  logic [2:0]     pressed_q, pressed_d;
  logic           statusHit, eventHit;
  logic [31:0]    statusWord, eventWord;

  assign cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  assign tick_d = (cnt_q == CNT_LAST);

  // The history holds the older samples; the incoming sync2 value completes the window.
  always_comb begin
    allOnes  = sync2_q;
    allZeros = ~sync2_q;
    for (int k = 0; k < int'(HIST); k++) begin
      allOnes  = allOnes & hist_q[k];
      allZeros = allZeros & ~hist_q[k];
    end
    hist_d  = hist_q;
    level_d = level_q;
    if (tick_q) begin
      hist_d[0] = sync2_q;
      for (int k = 1; k < int'(HIST); k++) begin
        hist_d[k] = hist_q[k-1];
      end
      level_d = (level_q | allOnes) & ~allZeros;
    end
  end

  assign pressed_q = ~level_q[12:10];
  assign pressed_d = ~level_d[12:10];

  assign statusWord = {19'b0, pressed_q, level_q[9:0]};
  assign eventWord  = {26'b0, event_q};

  // A same-edge set beats the read-to-clear so no event is ever dropped.
  always_comb begin
    statusHit   = dataRdEn && (dataAddress == STATUS_ADDR);
    eventHit    = dataRdEn && (dataAddress == EVENT_ADDR);
    readValid_d = statusHit || eventHit;
    readData_d  = '0;
    if (statusHit) begin
      readData_d = statusWord;
    end else if (eventHit) begin
      readData_d = eventWord;
    end
    event_d = (eventHit ? 6'b0 : event_q) |
              {pressed_q & ~pressed_d, pressed_d & ~pressed_q};
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1_q     <= RESET_LEVEL;
      sync2_q     <= RESET_LEVEL;
      hist_q      <= {HIST{RESET_LEVEL}};
      level_q     <= RESET_LEVEL;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      event_q     <= '0;
      readDataOut <= '0;
      readValid   <= 1'b0;
    end else begin
      sync1_q     <= {BUTTON, SW};
      sync2_q     <= sync1_q;
      hist_q      <= hist_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      event_q     <= event_d;
      readDataOut <= readData_d;
      readValid   <= readValid_d;
    end
  end

endmodule

// File: tb/tb_io_input_port.sv
// tb_io_input_port: bench for io_input_port with a cycle-level reference model,
// a decode vector table, directed debounce/event corner cases and random traffic.
module tb_io_input_port;

  localparam int TICK_DIV = 4;
  localparam int STABLE   = 3;
  localparam logic [15:0] STATUS_A = 16'h3FFE;
  localparam logic [15:0] EVENT_A  = 16'h3FFD;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic [15:0] dataAddress = '0;
  logic        dataRdEn = 1'b0;
  logic [9:0]  SW = '0;
  logic [2:0]  BUTTON = 3'b111;
  logic [31:0] readDataOut;
  logic        readValid;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic [15:0] addr;
    logic        rdEn;
    logic        expValid;
    logic [31:0] expData;
  } vec_t;

  io_input_port #(
    .TICK_DIV(TICK_DIV),
    .STABLE_SAMPLES(STABLE),
    .STATUS_ADDR(STATUS_A),
    .EVENT_ADDR(EVENT_A)
  ) dut (
    .clk(clk),
    .nRst(nRst),
    .dataAddress(dataAddress),
    .dataRdEn(dataRdEn),
    .SW(SW),
    .BUTTON(BUTTON),
    .readDataOut(readDataOut),
    .readValid(readValid)
  );

  always #5 clk = ~clk;

  // Reference model: counts edges since reset, delays raw pins two edges, keeps the
  // last STABLE tick samples per input and flips a level only on a unanimous window.
  int          edgeCount;
  logic [9:0]  swPipe [2];
  logic [2:0]  btnPipe [2];
  logic [9:0]  swHist [STABLE];
  logic [2:0]  btnHist [STABLE];
  logic [9:0]  swLevel;
  logic [2:0]  btnLevel;
  logic [2:0]  pressEv, releaseEv;
  logic        mValid;
  logic [31:0] mData;

  task automatic modelReset();
    edgeCount = 0;
    for (int p = 0; p < 2; p++) begin
      swPipe[p]  = '0;
      btnPipe[p] = 3'b111;
    end
    for (int k = 0; k < STABLE; k++) begin
      swHist[k]  = '0;
      btnHist[k] = 3'b111;
    end
    swLevel   = '0;
    btnLevel  = 3'b111;
    pressEv   = '0;
    releaseEv = '0;
    mValid    = 1'b0;
    mData     = '0;
  endtask

  task automatic modelEdge();
    logic [31:0] statusW, eventW;
    logic [9:0]  sSw;
    logic [2:0]  sBtn, oldPressed, newPressed;
    bit          isTick;
    int          ones;
    statusW = {19'b0, ~btnLevel, swLevel};
    eventW  = {26'b0, releaseEv, pressEv};
    mValid  = dataRdEn && (dataAddress == STATUS_A || dataAddress == EVENT_A);
    mData   = !mValid ? 32'h0 : ((dataAddress == STATUS_A) ? statusW : eventW);
    if (dataRdEn && dataAddress == EVENT_A) begin
      pressEv   = '0;
      releaseEv = '0;
    end
    edgeCount++;
    isTick = (edgeCount > TICK_DIV) && ((edgeCount - 1) % TICK_DIV == 0);
    sSw  = swPipe[1];
    sBtn = btnPipe[1];
    swPipe[1]  = swPipe[0];
    swPipe[0]  = SW;
    btnPipe[1] = btnPipe[0];
    btnPipe[0] = BUTTON;
    oldPressed = ~btnLevel;
    if (isTick) begin
      for (int k = STABLE - 1; k > 0; k--) begin
        swHist[k]  = swHist[k-1];
        btnHist[k] = btnHist[k-1];
      end
      swHist[0]  = sSw;
      btnHist[0] = sBtn;
      for (int b = 0; b < 10; b++) begin
        ones = 0;
        for (int k = 0; k < STABLE; k++) ones += int'(swHist[k][b]);
        if (ones == STABLE) swLevel[b] = 1'b1;
        else if (ones == 0) swLevel[b] = 1'b0;
      end
      for (int b = 0; b < 3; b++) begin
        ones = 0;
        for (int k = 0; k < STABLE; k++) ones += int'(btnHist[k][b]);
        if (ones == STABLE) btnLevel[b] = 1'b1;
        else if (ones == 0) btnLevel[b] = 1'b0;
      end
    end
    newPressed = ~btnLevel;
    pressEv   = pressEv | (newPressed & ~oldPressed);
    releaseEv = releaseEv | (oldPressed & ~newPressed);
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge nRst);
      if (!nRst) modelReset();
      else modelEdge();
    end
  end

  // True when the coming edge is a tick whose window makes button i read as pressed.
  function automatic bit pressLandsNext(input int i);
    bit ok;
    ok = (edgeCount + 1 > TICK_DIV) && (edgeCount % TICK_DIV == 0) &&
         (btnPipe[1][i] == 1'b0) && (btnLevel[i] == 1'b1);
    for (int k = 0; k < STABLE - 1; k++) begin
      if (btnHist[k][i] != 1'b0) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic checkOutput(input string name, input logic expValid, input logic [31:0] expData);
    testCount++;
    if (readValid !== expValid || readDataOut !== expData) begin
      failCount++;
      $display("[TB] FAIL %s: got valid=%0b data=%08h, expected valid=%0b data=%08h",
               name, readValid, readDataOut, expValid, expData);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic rdEn);
    dataAddress = addr;
    dataRdEn    = rdEn;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    checkOutput($sformatf("model@%0t", $time), mValid, mData);
  endtask

  task automatic readReg(input logic [15:0] addr, input string name, input logic [31:0] expData);
    applyStimulus(addr, 1'b1);
    step();
    checkOutput(name, 1'b1, expData);
    applyStimulus(16'h0000, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    bit   found;
    int   pick;
    vecs[0] = '{STATUS_A, 1'b1, 1'b1, 32'h155};
    vecs[1] = '{EVENT_A,  1'b1, 1'b1, 32'h0};
    vecs[2] = '{16'h3FFC, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{16'h3FFF, 1'b1, 1'b0, 32'h0};
    vecs[4] = '{STATUS_A, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{16'h0000, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{16'hBFFE, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{16'h7FFD, 1'b1, 1'b0, 32'h0};
    vecs[8] = '{EVENT_A,  1'b0, 1'b0, 32'h0};

    // Reset with switches driven high and a read pending.
    nRst = 1'b0;
    SW = 10'h3FF;
    BUTTON = 3'b111;
    applyStimulus(STATUS_A, 1'b1);
    repeat (3) step();
    checkOutput("reset outputs", 1'b0, 32'h0);

    nRst = 1'b1;
    SW = 10'h155;
    applyStimulus(STATUS_A, 1'b1);
    step();
    checkOutput("status while filling", 1'b1, 32'h0);
    repeat (20) step();
    checkOutput("switch debounce", 1'b1, 32'h155);
    applyStimulus(16'h0000, 1'b0);

    // Short button glitch must stay invisible.
    BUTTON = 3'b101;
    repeat (5) step();
    BUTTON = 3'b111;
    repeat (20) step();
    readReg(STATUS_A, "glitch status", 32'h155);
    readReg(EVENT_A, "glitch event", 32'h0);

    // Press then release, then two back-to-back EVENT reads.
    BUTTON = 3'b110;
    repeat (40) step();
    BUTTON = 3'b111;
    repeat (40) step();
    readReg(EVENT_A, "press/release event", 32'h9);
    readReg(EVENT_A, "second event read", 32'h0);

    // Press of button 2 lands on the same edge as an EVENT read.
    BUTTON = 3'b011;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (pressLandsNext(2)) found = 1'b1;
      else step();
    end
    if (!found) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL collision align: no aligned press within 40 cycles, expected one");
    end else begin
      readReg(EVENT_A, "collision read", 32'h0);
      readReg(EVENT_A, "collision next read", 32'h4);
    end
    BUTTON = 3'b111;
    repeat (40) step();
    readReg(EVENT_A, "release event 2", 32'h20);

    // Non-matching address and a write must leave a pending event alone.
    BUTTON = 3'b101;
    repeat (40) step();
    applyStimulus(16'h3FFC, 1'b1);
    step();
    checkOutput("decode 3FFC", 1'b0, 32'h0);
    applyStimulus(EVENT_A, 1'b0);
    step();
    checkOutput("write to EVENT", 1'b0, 32'h0);
    readReg(EVENT_A, "event kept", 32'h2);
    readReg(STATUS_A, "status pressed 1", 32'h955);
    BUTTON = 3'b111;
    repeat (40) step();
    readReg(EVENT_A, "release event 1", 32'h10);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].rdEn);
      step();
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expData);
    end
    applyStimulus(16'h0000, 1'b0);

    // Random pins and bus traffic, checked every cycle against the model.
    repeat (600) begin
      if ($urandom_range(19, 0) == 0) SW = 10'($urandom);
      if ($urandom_range(9, 0) == 0) BUTTON[$urandom_range(2, 0)] ^= 1'b1;
      pick = int'($urandom_range(3, 0));
      case (pick)
        0: applyStimulus(STATUS_A, 1'($urandom));
        1: applyStimulus(EVENT_A, 1'($urandom));
        2: applyStimulus(16'h3FFC, 1'($urandom));
        default: applyStimulus(16'($urandom), 1'($urandom));
      endcase
      step();
    end

    // Asynchronous reset in the middle of a read.
    applyStimulus(EVENT_A, 1'b1);
    step();
    nRst = 1'b0;
    BUTTON = 3'b111;
    SW = 10'h2AA;
    #1;
    checkOutput("async reset", 1'b0, 32'h0);
    repeat (3) step();
    nRst = 1'b1;
    applyStimulus(STATUS_A, 1'b1);
    step();
    checkOutput("status after reset", 1'b1, 32'h0);
    applyStimulus(16'h0000, 1'b0);
    repeat (30) step();
    readReg(EVENT_A, "no event from reset", 32'h0);
    readReg(STATUS_A, "status after settle", 32'h2AA);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/io_input_port.md
Name: io_input_port

Overview:
- Memory-mapped input peripheral; the read-side counterpart to the MMU's hex-display write port.
- Synchronizes and debounces board switches and push-buttons, and latches button press/release events into sticky bits.
- Presents both as CPU-readable registers in the top of data space, with the same 1-cycle read latency as the synchronous data RAM.
- The MMU muxes readDataOut onto the CPU read bus whenever readValid is high.

Parameters:
- TICK_DIV, 50000, clk cycles per debounce sample tick (1 ms at 50 MHz); must be >= 2.
- STABLE_SAMPLES, 4, number of consecutive equal tick samples needed to change a debounced level; range 2..8.
- STATUS_ADDR, 16'h3FFE, data address of the STATUS register.
- EVENT_ADDR, 16'h3FFD, data address of the EVENT register.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- nRst  input  1  reset, asynchronous, active-low.
- dataAddress  input  16  CPU data address, shared with the RAM.
- dataRdEn  input  1  CPU read strobe, valid in the same cycle as dataAddress.
- SW  input  10  raw slide switches, active-high, asynchronous to clk.
- BUTTON  input  3  raw push-buttons, active-low (0 = pressed), asynchronous.
- readDataOut  output  32  registered read data.
- readValid  output  1  registered; high when readDataOut holds a hit on this block.

Behaviour:
- Reset (nRst low, asynchronous):
  - Sync stages: SW to 0, BUTTON to 1.
  - Sample histories and debounced levels: switches 0, buttons released.
  - Prescaler 0; event bits 0; readDataOut 0; readValid 0.
- Synchronizer: two flops per input bit. The raw pin reaches sync2 two clocks later.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - Registered tick is high for exactly one cycle when count == TICK_DIV-1.
- Debounce, per input:
  - On tick, shift sync2 into a STABLE_SAMPLES-deep history.
  - If all STABLE_SAMPLES entries (the new sample included) are equal and differ from the debounced level, the debounced level takes that value on that same clock edge.
  - Any mismatch within the window leaves the level unchanged; glitches shorter than STABLE_SAMPLES ticks are never visible.
- Button polarity: internal pressed = ~debounced BUTTON.
- Events:
  - A debounced pressed 0->1 transition sets press[i].
  - A debounced pressed 1->0 transition sets release[i].
  - Bits are sticky: repeated edges while set do nothing further.
- STATUS register (read-only):
  - [9:0] debounced SW.
  - [12:10] pressed[2:0].
  - [31:13] zero.
- EVENT register (read-to-clear):
  - [2:0] press.
  - [5:3] release.
  - [31:6] zero.
- Read cycle:
  - If dataRdEn and dataAddress matches STATUS_ADDR or EVENT_ADDR, the next edge loads readDataOut with the register value as it stood before that edge, and sets readValid=1.
  - Otherwise the edge sets readValid=0 and readDataOut=0.
- Read-to-clear:
  - A read hit on EVENT_ADDR clears the event bits on the same edge that captures them.
  - If an event sets a bit on that same edge, set wins: the bit stays 1 for the next read, and the event is never lost.
- Back-to-back reads: each cycle is an independent read, so readValid can stay high continuously. A second consecutive EVENT read returns only events that arrived after the first.
- Writes: no write port. CPU writes to either address are ignored by this block; the RAM still receives them.
- Other addresses, or dataRdEn low: no effect on event bits.
- Reset mid-debounce or mid-read: everything returns to reset values immediately. No event is generated by reset release.

Test Plan:
(Bench parameters: TICK_DIV=4, STABLE_SAMPLES=3.)
- Reset: hold nRst low and drive SW=10'h3FF -> readValid=0, readDataOut=0. After release, while the debounce window is still filling, a STATUS read returns 0.
- Switch debounce: set SW=10'h155 and hold. A STATUS read about 20 cycles later -> 32'h00000155. Readback stays 0 until 3 ticks after sync.
- Glitch reject: pulse BUTTON[1]=0 for 5 cycles (under 3 ticks) -> STATUS[11]=0 and EVENT=0.
- Press/release: hold BUTTON[0]=0 for 40 cycles, then 1 for 40 cycles, then read EVENT -> 32'h00000009. An immediate second EVENT read -> 32'h00000000.
- Clear/set collision: align a BUTTON[2] debounced press with the EVENT-read edge -> that read returns bit 2 = 0; the next EVENT read returns 32'h00000004.
- Decode: read 16'h3FFC, and separately issue a write to 16'h3FFD -> readValid=0 next cycle in both cases, and pending event bits are unchanged.
